// File: rtl/vga_image_reader.sv
// VGA timing generator that streams a grayscale image from shared memory to the top-left of the screen.
// Define VGA_SCALE2_EN to draw the image at 2x scale (each memory word covers 2 pixels x 2 lines).
module vga_image_reader #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int IMG_W     = 256,
    parameter int IMG_H     = 256,
    parameter int IMG1_BASE = 65536,
    parameter int ADDR_W    = 17,
    parameter int PIX_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic              enableVGAX,
    input  logic              imageSelector,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic              hsync,
    output logic              vsync,
    output logic              video_on,
    output logic [PIX_W-1:0]  pixel,
    output logic              frame_start
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC - 1;

    localparam logic [HW-1:0]     H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]     V_LAST = VW'(V_TOTAL - 1);
    localparam logic [ADDR_W-1:0] BASE1  = ADDR_W'(IMG1_BASE);

    logic [HW-1:0]     hcnt;
    logic [VW-1:0]     vcnt;
    int                h_pos;
    int                v_pos;
    logic              line_end;
    logic              frame_end;
    logic              at_origin;
    logic              lat_en;
    logic              lat_sel;
    logic              eff_en;
    logic              eff_sel;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] fetch_addr;
    logic              in_area;
    logic              in_img;
    logic              s1_in;
    logic              s1_hs;
    logic              s1_vs;
    logic              s1_vid;
    logic              s1_fs;
    logic [PIX_W-1:0]  rdata_q;

    assign h_pos     = int'(hcnt);
    assign v_pos     = int'(vcnt);
    assign line_end  = (hcnt == H_LAST);
    assign frame_end = (vcnt == V_LAST);
    assign at_origin = (hcnt == '0) && (vcnt == '0);

    // The origin fetch must already use the values being latched for the new frame.
    assign eff_en  = at_origin ? enableVGAX    : lat_en;
    assign eff_sel = at_origin ? imageSelector : lat_sel;
    assign base    = eff_sel ? BASE1 : '0;
    assign in_img  = eff_en & in_area;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_en) begin
            if (line_end) begin
                hcnt <= '0;
                vcnt <= frame_end ? '0 : vcnt + VW'(1);
            end else begin
                hcnt <= hcnt + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_en  <= 1'b0;
            lat_sel <= 1'b0;
        end else if (pix_en && at_origin) begin
            lat_en  <= enableVGAX;
            lat_sel <= imageSelector;
        end
    end

`ifdef VGA_SCALE2_EN
    logic [ADDR_W-1:0] row_base;

    assign in_area    = (h_pos < 2 * IMG_W) && (v_pos < 2 * IMG_H) && (v_pos < V_ACTIVE);
    assign fetch_addr = at_origin ? base : row_base + ADDR_W'(hcnt[HW-1:1]);

    // Each image row is shown on two consecutive lines; advance after the odd one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_base <= '0;
        end else if (pix_en) begin
            if (at_origin) begin
                row_base <= base;
            end else if (line_end && vcnt[0]) begin
                row_base <= row_base + ADDR_W'(IMG_W);
            end
        end
    end
`else
    logic [ADDR_W-1:0] next_addr;

    assign in_area    = (h_pos < IMG_W) && (v_pos < IMG_H);
    assign fetch_addr = at_origin ? base : next_addr;

    // Image rows are contiguous in memory, so a running +1 pointer covers the whole frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            next_addr <= '0;
        end else if (pix_en && in_img) begin
            next_addr <= fetch_addr + ADDR_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
        end else begin
            mem_rd <= pix_en & in_img;
            if (pix_en && in_img) begin
                mem_addr <= fetch_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_in  <= 1'b0;
            s1_hs  <= 1'b1;
            s1_vs  <= 1'b1;
            s1_vid <= 1'b0;
            s1_fs  <= 1'b0;
        end else if (pix_en) begin
            s1_in  <= in_img;
            s1_hs  <= !((h_pos >= HS_START) && (h_pos <= HS_END));
            s1_vs  <= !((v_pos >= VS_START) && (v_pos <= VS_END));
            s1_vid <= (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
            s1_fs  <= at_origin;
        end
    end

    // Read data arrives the clk after mem_rd, which may be long before the next strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (mem_rd) begin
            rdata_q <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            pixel       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en & s1_fs;
            if (pix_en) begin
                hsync    <= s1_hs;
                vsync    <= s1_vs;
                video_on <= s1_vid;
                pixel    <= s1_in ? (mem_rd ? mem_rdata : rdata_q) : '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_image_reader.sv
// Self-checking bench for vga_image_reader: a small-timing instance checked every cycle against a
// position-arithmetic model, plus a default-parameter instance pinning the 640x480 line timing.
module tb_vga_image_reader;

    localparam int HA = 40, HF = 4, HS = 6, HB = 5, HT = HA + HF + HS + HB;
    localparam int VA = 30, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
    localparam int IW = 16, IH = 16, B1 = 4096;
    localparam int FRAME = HT * VT;
`ifdef VGA_SCALE2_EN
    localparam bit SCALE = 1'b1;
`else
    localparam bit SCALE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        reset_full = 1'b0;
    logic        pix_en = 1'b0;
    logic        en = 1'b0;
    logic        sel = 1'b0;
    logic [16:0] mem_addr, mem_addr_f;
    logic        mem_rd, mem_rd_f;
    logic [7:0]  mem_rdata, mem_rdata_f;
    logic        hsync, vsync, video_on, frame_start;
    logic        hsync_f, vsync_f, video_on_f, frame_start_f;
    logic [7:0]  pixel, pixel_f;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rel_cyc  = 0;
    bit rel_set  = 1'b0;

    function automatic logic [7:0] memf(input logic [16:0] a);
        return 8'(a ^ (a >> 5) ^ (a >> 12));
    endfunction

    assign mem_rdata   = memf(mem_addr);
    assign mem_rdata_f = memf(mem_addr_f);

    vga_image_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .IMG_W(IW), .IMG_H(IH), .IMG1_BASE(B1), .ADDR_W(17), .PIX_W(8)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .enableVGAX(en), .imageSelector(sel),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .pixel(pixel), .frame_start(frame_start)
    );

    vga_image_reader dut_full (
        .clk(clk), .reset(reset_full), .pix_en(1'b1),
        .enableVGAX(1'b1), .imageSelector(1'b0),
        .mem_addr(mem_addr_f), .mem_rd(mem_rd_f), .mem_rdata(mem_rdata_f),
        .hsync(hsync_f), .vsync(vsync_f), .video_on(video_on_f),
        .pixel(pixel_f), .frame_start(frame_start_f)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model (small instance) ----------------
    int          pcnt;
    bit          have_prev;
    int          ph, pv;
    bit          pin;
    logic [16:0] paddr;
    bit          m_en, m_sel;
    logic        exp_hs, exp_vs, exp_vid, exp_fs, exp_rd;
    logic [7:0]  exp_pix;
    logic [16:0] exp_addr;

    function automatic bit img_hit(input int h, input int v);
        if (SCALE) return (h < 2 * IW) && (v < 2 * IH) && (v < VA);
        return (h < IW) && (v < IH);
    endfunction

    function automatic logic [16:0] img_addr(input int h, input int v, input bit s);
        int b;
        b = s ? B1 : 0;
        if (SCALE) return 17'(b + (v / 2) * IW + h / 2);
        return 17'(b + v * IW + h);
    endfunction

    task automatic model_reset();
        pcnt = 0; have_prev = 0; pin = 0; paddr = '0; m_en = 0; m_sel = 0;
        exp_hs = 1; exp_vs = 1; exp_vid = 0; exp_fs = 0; exp_rd = 0;
        exp_pix = '0; exp_addr = '0;
    endtask

    task automatic model_step();
        int h, v;
        exp_rd = 0;
        exp_fs = 0;
        if (pix_en) begin
            h = pcnt % HT;
            v = (pcnt / HT) % VT;
            if (h == 0 && v == 0) begin
                m_en  = en;
                m_sel = sel;
            end
            if (have_prev) begin
                exp_hs  = !(ph >= HA + HF && ph < HA + HF + HS);
                exp_vs  = !(pv >= VA + VF && pv < VA + VF + VS);
                exp_vid = (ph < HA) && (pv < VA);
                exp_pix = pin ? memf(paddr) : 8'd0;
                exp_fs  = (ph == 0) && (pv == 0);
            end
            pin   = m_en && img_hit(h, v);
            paddr = img_addr(h, v, m_sel);
            if (pin) begin
                exp_rd   = 1;
                exp_addr = paddr;
            end
            ph = h;
            pv = v;
            have_prev = 1;
            pcnt++;
        end
    endtask

    always @(posedge clk) begin
        if (!reset) model_reset();
        else model_step();
    end

    // Compare process: every cycle, either reset values or the model's expectation.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("rst_hsync", hsync, 1);
            checkOutput("rst_vsync", vsync, 1);
            checkOutput("rst_video_on", video_on, 0);
            checkOutput("rst_pixel", pixel, 0);
            checkOutput("rst_frame_start", frame_start, 0);
            checkOutput("rst_mem_rd", mem_rd, 0);
            checkOutput("rst_mem_addr", mem_addr, 0);
        end else begin
            checkOutput("hsync", hsync, exp_hs);
            checkOutput("vsync", vsync, exp_vs);
            checkOutput("video_on", video_on, exp_vid);
            checkOutput("pixel", pixel, exp_pix);
            checkOutput("frame_start", frame_start, exp_fs);
            checkOutput("mem_rd", mem_rd, exp_rd);
            if (exp_rd) checkOutput("mem_addr", mem_addr, exp_addr);
        end
    end

    // ---------------- timing monitors for the first frame after release ----------------
    int hs_fall = -1, hs_rise = -1, vs_fall = -1, vs_rise = -1, fs1 = -1, fs2 = -1;
    int f_fall1 = -1, f_fall2 = -1, f_rise = -1;
    logic [7:0]  pix_h5 = '0, pix_h16 = '0;
    logic [16:0] f_line_addr = '0;
    logic        f_line_rd = 1'b0;
    logic        prev_hs = 1, prev_vs = 1, prev_hsf = 1;

    always @(negedge clk) begin
        if (rel_set) begin
            if (prev_hs && !hsync && hs_fall < 0) hs_fall = cyc - rel_cyc;
            if (!prev_hs && hsync && hs_rise < 0) hs_rise = cyc - rel_cyc;
            if (prev_vs && !vsync && vs_fall < 0) vs_fall = cyc - rel_cyc;
            if (!prev_vs && vsync && vs_rise < 0) vs_rise = cyc - rel_cyc;
            if (frame_start) begin
                if (fs1 < 0) fs1 = cyc - rel_cyc;
                else if (fs2 < 0) fs2 = cyc - rel_cyc;
            end
            if (cyc - rel_cyc == 6)  pix_h5  = pixel;
            if (cyc - rel_cyc == 17) pix_h16 = pixel;
            if (prev_hsf && !hsync_f) begin
                if (f_fall1 < 0) f_fall1 = cyc - rel_cyc;
                else if (f_fall2 < 0) f_fall2 = cyc - rel_cyc;
            end
            if (!prev_hsf && hsync_f && f_rise < 0) f_rise = cyc - rel_cyc;
            if (cyc - rel_cyc == (SCALE ? 1600 : 800)) begin
                f_line_addr = mem_addr_f;
                f_line_rd   = mem_rd_f;
            end
        end
        prev_hs  = hsync;
        prev_vs  = vsync;
        prev_hsf = hsync_f;
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input logic pe, input logic e, input logic s);
        @(negedge clk);
        #2;
        pix_en = pe;
        en     = e;
        sel    = s;
    endtask

    task automatic wait_pos(input int target);
        bit hit;
        hit = 0;
        for (int i = 0; i < 3 * FRAME && !hit; i++) begin
            applyStimulus(1'b1, en, sel);
            hit = (pcnt % FRAME == target);
        end
        checkOutput("wait_pos_reached", hit, 1);
    endtask

    initial begin
        int rd_cnt, vid_cnt, pix_cnt;

        // Reset held with pix_en running, then continuous pix_en, image 0.
        pix_en = 1; en = 1; sel = 0;
        repeat (5) @(negedge clk);
        #2;
        reset = 1;
        reset_full = 1;
        @(negedge clk);
        rel_cyc = cyc;
        rel_set = 1;
        repeat (2 * FRAME + 100) @(negedge clk);

        checkOutput("hsync_fall_offset", hs_fall, HA + HF + 1);
        checkOutput("hsync_low_width", hs_rise - hs_fall, HS);
        checkOutput("vsync_low_width", vs_rise - vs_fall, VS * HT);
        checkOutput("vsync_fall_offset", vs_fall, (VA + VF) * HT + 1);
        checkOutput("frame_start_first", fs1, 1);
        checkOutput("frame_period", fs2 - fs1, FRAME);
        checkOutput("pixel_h5", pix_h5, SCALE ? 2 : 5);
        checkOutput("pixel_h16", pix_h16, SCALE ? 8 : 0);
        checkOutput("full_hsync_fall_offset", f_fall1, 657);
        checkOutput("full_hsync_low_width", f_rise - f_fall1, 96);
        checkOutput("full_line_period", f_fall2 - f_fall1, 800);
        checkOutput("full_line_addr", f_line_addr, 256);
        checkOutput("full_line_rd", f_line_rd, 1);

        // Select switched mid-frame: takes effect at the next origin fetch.
        wait_pos(10 * HT);
        applyStimulus(1'b1, 1'b1, 1'b1);
        wait_pos(1);
        checkOutput("sel_next_frame_addr", mem_addr, B1);
        checkOutput("sel_next_frame_rd", mem_rd, 1);
        repeat (HT * 3) applyStimulus(1'b1, 1'b1, 1'b1);

        // Enable dropped mid-frame: next frame has no reads, black pixels, normal timing.
        wait_pos(10 * HT);
        applyStimulus(1'b1, 1'b0, 1'b1);
        wait_pos(1);
        rd_cnt = 0; vid_cnt = 0; pix_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            rd_cnt  += int'(mem_rd);
            vid_cnt += int'(video_on);
            pix_cnt += int'(pixel != 0);
        end
        checkOutput("disabled_frame_reads", rd_cnt, 0);
        checkOutput("disabled_frame_video_on", vid_cnt, HA * VA);
        checkOutput("disabled_frame_pixels", pix_cnt, 0);

        // 1-in-4 pix_en strobe with random enable/select changes.
        for (int i = 0; i < 4 * FRAME + 200; i++) begin
            if (i % 500 == 0) begin
                en  = ($urandom_range(0, 3) != 0);
                sel = $urandom_range(0, 1);
            end
            applyStimulus(i % 4 == 0, en, sel);
        end

        // Fully random pix_en pattern.
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (i % 700 == 0) begin
                en  = ($urandom_range(0, 3) != 0);
                sel = $urandom_range(0, 1);
            end
            applyStimulus($urandom_range(0, 2) == 0, en, sel);
        end

        // Mid-line reset inside the image area.
        applyStimulus(1'b1, 1'b1, 1'b0);
        wait_pos(1);
        wait_pos(5 * HT + 31);
        @(negedge clk);
        #2;
        reset = 0;
        #1;
        checkOutput("midrst_video_on", video_on, 0);
        checkOutput("midrst_pixel", pixel, 0);
        checkOutput("midrst_hsync", hsync, 1);
        checkOutput("midrst_vsync", vsync, 1);
        checkOutput("midrst_mem_rd", mem_rd, 0);
        checkOutput("midrst_mem_addr", mem_addr, 0);
        repeat (3) @(negedge clk);
        #2;
        reset = 1;
        @(negedge clk);
        checkOutput("post_rst_first_addr", mem_addr, 0);
        checkOutput("post_rst_first_rd", mem_rd, 1);
        repeat (FRAME + 50) applyStimulus(1'b1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
